apu_frame_sequencer: RTL and testbench
======================================

APU_FRAME_SEQUENCER -- requirements
Module: apu_frame_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 15, giving the APU-cycle counter width.
REQ-002 SHALL have parameter STEPS_NTSC, default {18640,14914,11185,7456,3728}: packed 5×CNT_W, step 1 in the LSBs.
REQ-003 SHALL have parameter STEPS_PAL, default {20782,16626,12469,8313,4156}, with the same packing.
REQ-004 SHALL have parameters WR_DLY_EVEN (default 2) and WR_DLY_ODD (default 3): apu_clk_pulse count from write detect to write apply.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 apu_clk_pulse  in  1  one-clk strobe per APU cycle.
REQ-008 cpu_odd  in  1  high while the current CPU cycle is odd.
REQ-009 pal  in  1  region select (1 = STEPS_PAL).
REQ-010 to_apu  in  2  $4017 data: [1] = sequence mode, [0] = IRQ inhibit.
REQ-011 mode_wren  in  1  $4017 write enable; may stay high for several clks.
REQ-012 irq_ack  in  1  one-clk strobe from a $4015 status read.
REQ-013 e_pulse  out  1  quarter-frame pulse (envelope, linear counter).
REQ-014 l_pulse  out  1  half-frame pulse (length counter, sweep).
REQ-015 f_pulse  out  1  end-of-sequence pulse.
REQ-016 irq  out  1  frame IRQ flag, level.

Function
REQ-017 All outputs SHALL be registered; e_pulse, l_pulse and f_pulse SHALL be exactly one clk wide.
REQ-018 The counter SHALL increment by 1 on each apu_clk_pulse; pulses fire in the clk after the apu_clk_pulse on which the counter equals the step value.
REQ-019 The active table SHALL be latched from pal only when the counter wraps to 0 or a write is applied; a pal change mid-sequence has no effect until then.
REQ-020 Step 1 and step 3 SHALL assert e_pulse; step 2 SHALL assert e_pulse and l_pulse.
REQ-021 Mode 0, step 4: SHALL assert e_pulse, l_pulse and f_pulse, set irq if inhibit=0, and wrap the counter to 0.
REQ-022 Mode 1: step 4 SHALL produce nothing; step 5 SHALL assert e_pulse, l_pulse and f_pulse and wrap to 0; irq is never set.
REQ-023 A rising edge of mode_wren SHALL capture to_apu and cpu_odd and arm a delay of WR_DLY_ODD (cpu_odd=1) or WR_DLY_EVEN apu_clk_pulses.
REQ-024 A new rising edge during a pending delay SHALL replace the data and restart the delay.
REQ-025 On apply: counter ← 0, mode and inhibit updated, table relatched, and irq cleared if new inhibit=1.
REQ-026 On apply with new mode=1, e_pulse and l_pulse SHALL assert in the same clk.
REQ-027 An apply SHALL suppress any step pulse due in that apu cycle.
REQ-028 irq_ack SHALL clear irq in the next clk; a simultaneous set wins.
REQ-029 Arithmetic SHALL be unsigned CNT_W bits; the counter never passes the last step of the active mode.

Reset
REQ-030 While rst is high: counter 0, mode 0, inhibit 1, table NTSC, no pending write, irq 0, all pulses 0.
REQ-031 Reset asserted mid-delay SHALL discard the pending write.
REQ-032 After release, counting SHALL resume on the first apu_clk_pulse.

Verification
REQ-033 Reset, pal=0, apu_clk_pulse every clk -> e_pulse at counts 3728/7456/11185/14914, l_pulse at 7456/14914, f_pulse at 14914, irq stays 0, then the sequence repeats.
REQ-034 Write to_apu=00 with cpu_odd=1 -> apply after 3 apu pulses; at count 14914 irq=1; irq_ack -> irq=0 next clk.
REQ-035 Write to_apu=10 -> immediate e_pulse+l_pulse at apply; next pulses at 3728/7456/11185/18640; irq never set.
REQ-036 Raise pal at count 5000 -> remainder stays NTSC; the next sequence steps at 4156/8313/12469/16626.
REQ-037 irq=1, then write to_apu=01 -> irq cleared at apply; irq_ack coincident with step-4 set -> irq=1.

Source files
------------

// File: rtl/apu_frame_sequencer.sv
// apu_frame_sequencer
//   APU frame sequencer: counts APU cycles and emits quarter-frame (e_pulse),
//   half-frame (l_pulse) and end-of-sequence (f_pulse) strobes from an NTSC or
//   PAL step table. It also maintains the frame IRQ flag and applies $4017
//   writes after a CPU-parity-dependent delay.
//
// Ports
//   clk, rst       system clock; asynchronous active-high reset
//   apu_clk_pulse  one-clk strobe per APU cycle
//   cpu_odd        high while the current CPU cycle is odd
//   pal            region select (1 = PAL table)
//   to_apu[1:0]    $4017 data: [1] sequence mode, [0] IRQ inhibit
//   mode_wren      $4017 write enable (rising edge detected)
//   irq_ack        $4015 read strobe, clears irq
//   e_pulse        quarter-frame pulse
//   l_pulse        half-frame pulse
//   f_pulse        end-of-sequence pulse
//   irq            frame IRQ flag (level)
module apu_frame_sequencer #(
  parameter int unsigned        CNT_W       = 15,
  parameter logic [5*CNT_W-1:0] STEPS_NTSC  = {CNT_W'(18640), CNT_W'(14914), CNT_W'(11185),
                                               CNT_W'(7456),  CNT_W'(3728)},
  parameter logic [5*CNT_W-1:0] STEPS_PAL   = {CNT_W'(20782), CNT_W'(16626), CNT_W'(12469),
                                               CNT_W'(8313),  CNT_W'(4156)},
  parameter int unsigned        WR_DLY_EVEN = 2,
  parameter int unsigned        WR_DLY_ODD  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       apu_clk_pulse,
  input  logic       cpu_odd,
  input  logic       pal,
  input  logic [1:0] to_apu,
  input  logic       mode_wren,
  input  logic       irq_ack,
  output logic       e_pulse,
  output logic       l_pulse,
  output logic       f_pulse,
  output logic       irq
);

  localparam int unsigned DLY_MAX = (WR_DLY_ODD > WR_DLY_EVEN) ? WR_DLY_ODD : WR_DLY_EVEN;
  localparam int unsigned DLY_W   = (DLY_MAX < 2) ? 1 : $clog2(DLY_MAX + 1);

  typedef enum logic {
    WR_IDLE,
    WR_PEND
  } wr_state_t;

  wr_state_t          wr_state_q, wr_state_d;
  logic [1:0]         wr_data_q, wr_data_d;
  logic [DLY_W-1:0]   dly_q, dly_d, dly_load;
  logic               wren_q;
  logic               wr_rise;
  logic               apply;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               inh_q, inh_d;
  logic               tbl_pal_q, tbl_pal_d;
  logic               e_d, l_d, f_d, irq_d;

  logic [5*CNT_W-1:0] steps;
  logic [CNT_W-1:0]   step1, step2, step3, step4, step5, last_step;

  assign wr_rise  = mode_wren & ~wren_q;
  assign dly_load = cpu_odd ? DLY_W'(WR_DLY_ODD) : DLY_W'(WR_DLY_EVEN);

  assign steps     = tbl_pal_q ? STEPS_PAL : STEPS_NTSC;
  assign step1     = steps[0*CNT_W +: CNT_W];
  assign step2     = steps[1*CNT_W +: CNT_W];
  assign step3     = steps[2*CNT_W +: CNT_W];
  assign step4     = steps[3*CNT_W +: CNT_W];
  assign step5     = steps[4*CNT_W +: CNT_W];
  assign last_step = mode_q ? step5 : step4;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_data_d  = wr_data_q;
    dly_d      = dly_q;
    apply      = 1'b0;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    inh_d      = inh_q;
    tbl_pal_d  = tbl_pal_q;
    e_d        = 1'b0;
    l_d        = 1'b0;
    f_d        = 1'b0;
    irq_d      = irq_ack ? 1'b0 : irq;

    // A new write edge always re-arms, even if the old delay would have
    // expired on this very APU cycle; the old write is then dropped.
    case (wr_state_q)
      WR_IDLE: begin
        if (wr_rise) begin
          wr_state_d = WR_PEND;
          wr_data_d  = to_apu;
          dly_d      = dly_load;
        end
      end
      WR_PEND: begin
        if (wr_rise) begin
          wr_data_d = to_apu;
          dly_d     = dly_load;
        end else if (apu_clk_pulse) begin
          if (dly_q <= DLY_W'(1)) begin
            apply      = 1'b1;
            wr_state_d = WR_IDLE;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    if (apply) begin
      // Apply takes the place of whatever step was due this APU cycle.
      cnt_d     = '0;
      mode_d    = wr_data_q[1];
      inh_d     = wr_data_q[0];
      tbl_pal_d = pal;
      if (wr_data_q[0]) begin
        irq_d = 1'b0;
      end
      if (wr_data_q[1]) begin
        e_d = 1'b1;
        l_d = 1'b1;
      end
    end else if (apu_clk_pulse) begin
      // >= keeps the counter bounded by the last step of the active mode.
      if (cnt_q >= last_step) begin
        e_d       = 1'b1;
        l_d       = 1'b1;
        f_d       = 1'b1;
        cnt_d     = '0;
        tbl_pal_d = pal;
        if (!mode_q && !inh_q) begin
          irq_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == step1 || cnt_q == step3) begin
          e_d = 1'b1;
        end else if (cnt_q == step2) begin
          e_d = 1'b1;
          l_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      wr_data_q  <= '0;
      dly_q      <= '0;
      wren_q     <= 1'b0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      inh_q      <= 1'b1;
      tbl_pal_q  <= 1'b0;
      e_pulse    <= 1'b0;
      l_pulse    <= 1'b0;
      f_pulse    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_data_q  <= wr_data_d;
      dly_q      <= dly_d;
      wren_q     <= mode_wren;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      inh_q      <= inh_d;
      tbl_pal_q  <= tbl_pal_d;
      e_pulse    <= e_d;
      l_pulse    <= l_d;
      f_pulse    <= f_d;
      irq        <= irq_d;
    end
  end

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Testbench for apu_frame_sequencer: a behavioural model predicts
// {e_pulse,l_pulse,f_pulse,irq} for every clk; a monitor compares them.
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       apu_clk_pulse;
  logic       cpu_odd;
  logic       pal;
  logic [1:0] to_apu;
  logic       mode_wren;
  logic       irq_ack;
  logic       e_pulse;
  logic       l_pulse;
  logic       f_pulse;
  logic       irq;

  apu_frame_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .apu_clk_pulse (apu_clk_pulse),
    .cpu_odd       (cpu_odd),
    .pal           (pal),
    .to_apu        (to_apu),
    .mode_wren     (mode_wren),
    .irq_ack       (irq_ack),
    .e_pulse       (e_pulse),
    .l_pulse       (l_pulse),
    .f_pulse       (f_pulse),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int obs_e  = 0;
  int obs_l  = 0;
  int obs_f  = 0;
  logic [3:0] exp_q[$];

  // Reference model state
  int   steps_ntsc[5] = '{3728, 7456, 11185, 14914, 18640};
  int   steps_pal[5]  = '{4156, 8313, 12469, 16626, 20782};
  int   m_cnt    = 0;
  bit   m_mode   = 0;
  bit   m_inh    = 1;
  bit   m_pal    = 0;
  bit   m_pend   = 0;
  int   m_remain = 0;
  bit   m_irq    = 0;
  bit   m_prev   = 0;
  bit [1:0] m_data = 2'b00;

  task automatic model_step();
    bit e, l, f, nirq, rise, fire;
    int idx, last;
    e = 0; l = 0; f = 0;
    if (rst) begin
      m_cnt = 0; m_mode = 0; m_inh = 1; m_pal = 0;
      m_pend = 0; m_remain = 0; m_irq = 0; m_prev = 0;
    end else begin
      nirq = irq_ack ? 1'b0 : m_irq;
      rise = mode_wren && !m_prev;
      m_prev = mode_wren;
      fire = 0;
      if (rise) begin
        m_pend = 1; m_data = to_apu; m_remain = cpu_odd ? 3 : 2;
      end else if (m_pend && apu_clk_pulse) begin
        m_remain = m_remain - 1;
        if (m_remain == 0) fire = 1;
      end
      if (fire) begin
        m_pend = 0; m_cnt = 0;
        m_mode = m_data[1]; m_inh = m_data[0]; m_pal = pal;
        if (m_inh) nirq = 0;
        if (m_mode) begin e = 1; l = 1; end
      end else if (apu_clk_pulse) begin
        idx = -1;
        for (int unsigned i = 0; i < 5; i++)
          if ((m_pal ? steps_pal[i] : steps_ntsc[i]) == m_cnt) idx = int'(i);
        last = m_mode ? 4 : 3;
        if (idx == last) begin
          e = 1; l = 1; f = 1;
          if (!m_mode && !m_inh) nirq = 1;
          m_cnt = 0; m_pal = pal;
        end else begin
          if (idx == 0 || idx == 2) e = 1;
          if (idx == 1) begin e = 1; l = 1; end
          m_cnt = m_cnt + 1;
        end
      end
      m_irq = nirq;
    end
    exp_q.push_back({e, l, f, m_irq});
  endtask

  task automatic cycle(input bit r, input bit apu, input bit wren, input bit [1:0] din,
                       input bit odd, input bit pl, input bit ack);
    @(negedge clk);
    rst = r; apu_clk_pulse = apu; mode_wren = wren; to_apu = din;
    cpu_odd = odd; pal = pl; irq_ack = ack;
    model_step();
  endtask

  task automatic tick(input bit pl, input bit ack);
    cycle(0, 1, 0, 2'($urandom), 1'($urandom), pl, ack);
  endtask

  task automatic wr(input bit [1:0] din, input bit odd, input bit pl, input int hold);
    cycle(0, 1, 1, din, odd, pl, 0);
    for (int i = 1; i < hold; i++) cycle(0, 1, 1, 2'($urandom), 1'($urandom), pl, 0);
    cycle(0, 1, 0, 2'($urandom), 1'($urandom), pl, 0);
  endtask

  task automatic run_to(input int target, input bit pl);
    int guard = 0;
    while (m_cnt != target && guard < 40000) begin
      tick(pl, 0);
      guard++;
    end
    if (m_cnt != target) begin
      $display("FAIL run_to count=%0d required=%0d", m_cnt, target);
      $fatal(1, "stimulus bound expired");
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: one expected output word per clk
  initial begin
    logic [3:0] exp_v, act_v;
    int mon_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {e_pulse, l_pulse, f_pulse, irq};
        mon_cyc++;
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs cyc=%0d {e,l,f,irq} actual=%b required=%b", mon_cyc, act_v, exp_v);
        end
        obs_e += int'(e_pulse);
        obs_l += int'(l_pulse);
        obs_f += int'(f_pulse);
      end
    end
  end

  initial begin
    int se, sl, sf;
    bit rb, wl;
    rst = 1; apu_clk_pulse = 0; cpu_odd = 0; pal = 0;
    to_apu = 2'b00; mode_wren = 0; irq_ack = 0;

    // Default sequence after reset: NTSC, mode 0, inhibited
    repeat (3) cycle(1, 1, 0, 2'b00, 0, 0, 0);
    se = obs_e; sl = obs_l; sf = obs_f;
    repeat (14915) tick(0, $urandom_range(0, 511) == 0);
    tick(0, 0);
    chk("seq0_e_count", obs_e - se, 4);
    chk("seq0_l_count", obs_l - sl, 2);
    chk("seq0_f_count", obs_f - sf, 1);
    // Apply landing on step 2 suppresses it
    run_to(7454, 0);
    wr(2'b01, 0, 0, 1);
    repeat (20) tick(0, 0);

    // Odd-cycle write, IRQ enabled; PAL raised mid-sequence
    wr(2'b00, 1, 0, 1 + $urandom_range(0, 2));
    run_to(5000, 0);
    run_to(14914, 1);
    tick(1, 1);
    repeat (5) tick(1, 0);
    tick(1, 1);
    repeat (3) tick(1, 0);
    run_to(16626, 1);
    tick(1, 0);
    repeat (4) tick(1, 0);
    wr(2'b01, 0, 1, 2);
    repeat (10) tick(1, 0);

    // Five-step mode
    se = obs_e; sl = obs_l; sf = obs_f;
    wr(2'b10, 1'($urandom), 0, 1 + $urandom_range(0, 2));
    repeat (18645) tick(0, $urandom_range(0, 511) == 0);
    tick(0, 0);
    chk("mode1_e_count", obs_e - se, 5);
    chk("mode1_l_count", obs_l - sl, 3);
    chk("mode1_f_count", obs_f - sf, 1);

    // Reset during a pending write discards it
    wr(2'b11, 1, 0, 1);
    repeat (2) cycle(1, 1, 0, 2'b00, 0, 0, 0);
    se = obs_e;
    repeat (10) tick(0, 0);
    tick(0, 0);
    chk("reset_drops_write_e", obs_e - se, 0);

    // Random traffic
    wl = 0;
    for (int unsigned i = 0; i < 3000; i++) begin
      rb = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 5) == 0) wl = !wl;
      cycle(rb, 1'($urandom), wl, 2'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0);
    end
    repeat (2) cycle(0, 0, 0, 2'b00, 0, 0, 0);

    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
